// File: rtl/ahb_defs_pkg.sv
// Shared AHB-Lite definitions for the slave-side interconnect.
// HTRANS/HRESP codes, data-phase select encodings, default-slave states.
package ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase select: 0..15 are slave port indices, above that the
  // internal default slave and "no data phase in progress".
  localparam int         DSEL_W    = 5;
  localparam logic [4:0] DSEL_DEF  = 5'd16;
  localparam logic [4:0] DSEL_NONE = 5'd17;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // NONSEQ and SEQ start a data phase; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahblite_interconnect_n_default_slave.sv
// Default slave: answers unmapped accesses with the two-cycle ERROR response.
// Optional error log enabled by AHB_ICT_ERRLOG_EN.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no unmapped data phase, zero-wait OKAY
// ERR1    | first ERROR cycle, HREADY low
// ERR2    | second ERROR cycle, HREADY high, may accept next
module ahblite_default_slave
  import ahb_defs::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        def_accept,
  output logic        def_hready,
  output logic        def_hresp
`ifdef AHB_ICT_ERRLOG_EN
  ,
  input  logic [31:0] HADDR,
  input  logic        ERR_CLR,
  output logic        ERR_VALID,
  output logic [31:0] ERR_ADDR
`endif
);

  ds_state_t state, state_nxt;

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= DS_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and response outputs
  always_comb begin
    state_nxt  = state;
    def_hready = 1'b1;
    def_hresp  = HRESP_OKAY;
    case (state)
      DS_IDLE: begin
        if (def_accept) state_nxt = DS_ERR1;
      end
      DS_ERR1: begin
        def_hready = 1'b0;
        def_hresp  = HRESP_ERROR;
        state_nxt  = DS_ERR2;
      end
      DS_ERR2: begin
        def_hready = 1'b1;
        def_hresp  = HRESP_ERROR;
        state_nxt  = def_accept ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

`ifdef AHB_ICT_ERRLOG_EN
  // First unmapped address is latched; clear only drops the valid flag
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= 32'h0;
    end else if (def_accept && !ERR_VALID) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= HADDR;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ahblite_interconnect_n.sv
// Parametrised AHB-Lite slave-side interconnect: address decode, HSEL
// generation, data-phase response mux and HREADY generation.
// Optional error log enabled by AHB_ICT_ERRLOG_EN.
module ahblite_interconnect_n
  import ahb_defs::*;
#(
  parameter int NUM_PORTS = 4,
  parameter logic [32*NUM_PORTS-1:0] PORT_BASE =
    {32'h4000_0010, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [32*NUM_PORTS-1:0] PORT_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hF000_0000, 32'hF000_0000}
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic [31:0]             HRDATA,
  output logic                    HREADY,
  output logic                    HRESP,
  output logic [NUM_PORTS-1:0]    HSEL_S,
  input  logic [NUM_PORTS-1:0]    HREADYOUT_S,
  input  logic [32*NUM_PORTS-1:0] HRDATA_S,
  input  logic [NUM_PORTS-1:0]    HRESP_S
`ifdef AHB_ICT_ERRLOG_EN
  ,
  input  logic                    ERR_CLR,
  output logic                    ERR_VALID,
  output logic [31:0]             ERR_ADDR
`endif
);

  logic              hit_any;
  logic [DSEL_W-1:0] win_idx;
  logic [DSEL_W-1:0] dsel;
  logic              accept;
  logic              def_accept;
  logic              def_hready;
  logic              def_hresp;

  // Address decode; scanning downward lets the lowest matching port win
  always_comb begin
    hit_any = 1'b0;
    win_idx = '0;
    HSEL_S  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]) begin
        hit_any   = 1'b1;
        win_idx   = DSEL_W'(i);
        HSEL_S    = '0;
        HSEL_S[i] = 1'b1;
      end
    end
  end

  assign accept     = HREADY && htrans_active(HTRANS);
  assign def_accept = accept && !hit_any;

  // Data-phase select: loaded on every ready cycle, held across wait states
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel <= DSEL_NONE;
    end else if (HREADY) begin
      if (accept) dsel <= hit_any ? win_idx : DSEL_DEF;
      else        dsel <= DSEL_NONE;
    end
  end

  // Response mux driven by the data-phase owner
  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = 32'h0;
    if (dsel == DSEL_DEF) begin
      HREADY = def_hready;
      HRESP  = def_hresp;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dsel == DSEL_W'(i)) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
        HRDATA = HRDATA_S[32*i +: 32];
      end
    end
  end

  ahblite_default_slave u_default_slave (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .def_accept (def_accept),
    .def_hready (def_hready),
    .def_hresp  (def_hresp)
`ifdef AHB_ICT_ERRLOG_EN
    ,
    .HADDR      (HADDR),
    .ERR_CLR    (ERR_CLR),
    .ERR_VALID  (ERR_VALID),
    .ERR_ADDR   (ERR_ADDR)
`endif
  );

endmodule
